// File: rtl/req_ack_rr_arbiter_pkg.sv
// Shared definitions for the req/ack round-robin arbiter.
//   - state encoding for the arbiter FSM (IDLE / ISSUE / RESP)
//   - width of the completed-transaction counter
package arb_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_RESP  = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        ISSUE = ST_ISSUE,
        RESP  = ST_RESP
    } arb_state_t;

    localparam int COUNT_W = 32;

endpackage

// File: rtl/req_ack_rr_arbiter_rr_pick.sv
// Rotating-priority picker (purely combinational).
// Ports:
//   req     : per-client request vector
//   ptr     : client index holding highest priority this round
//   gnt_idx : first requesting client found searching ptr, ptr+1, ... with wrap
//   any     : at least one request bit is set
module rr_pick #(
    parameter int num_clients = 4,
    localparam int PW = $clog2(num_clients)
) (
    input  logic [num_clients-1:0] req,
    input  logic [PW-1:0]          ptr,
    output logic [PW-1:0]          gnt_idx,
    output logic                   any
);

    int idx;

    // Walk offsets from farthest to nearest so the nearest match to ptr
    // is the one that survives.
    always_comb begin
        any     = |req;
        gnt_idx = '0;
        idx     = 0;
        for (int k = num_clients - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % num_clients;
            if (req[idx]) gnt_idx = PW'(idx);
        end
    end

endmodule

// File: rtl/req_ack_rr_arbiter.sv
// Round-robin arbiter sharing one req/ack data source among several clients.
// Each granted request fetches one word from the source and returns it to the
// winner as a one-cycle ack pulse; a zero-wait source gives one word per 4 cycles.
// Ports:
//   clk, rst          : clock (rising edge), async active-high reset
//   cli_req / cli_ack : per-client request level / one-cycle ack pulse
//   cli_dout          : shared return data, valid with any cli_ack bit
//   src_req / src_ack : request to / one-cycle ack from the source
//   src_din           : source data, valid with src_ack
//   grant_id          : current or last winner
//   busy              : FSM not in IDLE
//   count             : completed transactions (wraps)
//   err               : sticky, src_ack seen outside ISSUE
module req_ack_rr_arbiter
    import arb_pkg::*;
#(
    parameter int num_clients = 4,
    parameter int data_width  = 32,
    localparam int GW = $clog2(num_clients)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [num_clients-1:0] cli_req,
    output logic [num_clients-1:0] cli_ack,
    output logic [data_width-1:0]  cli_dout,
    output logic                   src_req,
    input  logic                   src_ack,
    input  logic [data_width-1:0]  src_din,
    output logic [GW-1:0]          grant_id,
    output logic                   busy,
    output logic [COUNT_W-1:0]     count,
    output logic                   err
);

    arb_state_t             state, state_n;
    logic [GW-1:0]          ptr, ptr_n;
    logic [GW-1:0]          gid_n;
    logic                   src_req_n;
    logic [num_clients-1:0] cli_ack_n;
    logic [data_width-1:0]  dout_n;
    logic [COUNT_W-1:0]     count_n;
    logic                   err_n;

    logic [GW-1:0]          pick_idx;
    logic                   pick_any;

    rr_pick #(.num_clients(num_clients)) u_pick (
        .req     (cli_req),
        .ptr     (ptr),
        .gnt_idx (pick_idx),
        .any     (pick_any)
    );

    assign busy = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            src_req  <= 1'b0;
            cli_ack  <= '0;
            cli_dout <= '0;
            grant_id <= '0;
            ptr      <= '0;
            count    <= '0;
            err      <= 1'b0;
        end else begin
            state    <= state_n;
            src_req  <= src_req_n;
            cli_ack  <= cli_ack_n;
            cli_dout <= dout_n;
            grant_id <= gid_n;
            ptr      <= ptr_n;
            count    <= count_n;
            err      <= err_n;
        end
    end

    always_comb begin
        state_n   = state;
        src_req_n = src_req;
        cli_ack_n = cli_ack;
        dout_n    = cli_dout;
        gid_n     = grant_id;
        ptr_n     = ptr;
        count_n   = count;
        err_n     = err;
        case (state)
            IDLE: begin
                if (src_ack) err_n = 1'b1;
                if (pick_any) begin
                    gid_n     = pick_idx;
                    src_req_n = 1'b1;
                    state_n   = ISSUE;
                end
            end
            ISSUE: begin
                // The grant is already registered, so a client dropping its
                // request here still receives the word.
                if (src_ack) begin
                    src_req_n = 1'b0;
                    dout_n    = src_din;
                    cli_ack_n = num_clients'(1) << grant_id;
                    count_n   = count + COUNT_W'(1);
                    state_n   = RESP;
                end
            end
            RESP: begin
                if (src_ack) err_n = 1'b1;
                cli_ack_n = '0;
                // Winner drops to lowest priority next round.
                ptr_n   = (int'(grant_id) == num_clients - 1) ? '0 : grant_id + GW'(1);
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_req_ack_rr_arbiter.sv
module tb_req_ack_rr_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  cli_req;
    logic [N-1:0]  cli_ack;
    logic [DW-1:0] cli_dout;
    logic          src_req;
    logic          src_ack;
    logic [DW-1:0] src_din;
    logic [1:0]    grant_id;
    logic          busy;
    logic [31:0]   count;
    logic          err;

    req_ack_rr_arbiter #(.num_clients(N), .data_width(DW)) dut (
        .clk      (clk),
        .rst      (rst),
        .cli_req  (cli_req),
        .cli_ack  (cli_ack),
        .cli_dout (cli_dout),
        .src_req  (src_req),
        .src_ack  (src_ack),
        .src_din  (src_din),
        .grant_id (grant_id),
        .busy     (busy),
        .count    (count),
        .err      (err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    // ---------------- source model (producer with wait states) -------------
    int          fail_rate = 0;
    bit          inject    = 0;
    bit          prev_req  = 0;
    int unsigned next_val  = 0;

    // Updated 1 time unit after each edge; the value stands for the
    // registered ack a producer would present during the following cycle.
    initial begin
        src_ack = 1'b0;
        src_din = '0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                src_ack  = 1'b0;
                prev_req = 1'b0;
            end else if (inject) begin
                src_ack  = 1'b1;
                inject   = 0;
                prev_req = src_req;
            end else begin
                if (prev_req && !src_ack && ($urandom_range(0, 99) >= fail_rate)) begin
                    src_ack = 1'b1;
                    src_din = next_val;
                    next_val++;
                end else begin
                    src_ack = 1'b0;
                end
                prev_req = src_req;
            end
        end
    end

    // ---------------- reference model -------------------------------------
    typedef struct {
        int          cli;
        logic [31:0] data;
    } exp_t;

    exp_t        exp_q[$];
    int          m_phase = 0;   // 0 waiting for requests, 1 word outstanding, 2 delivering
    int          m_ptr   = 0;
    int          m_win   = 0;
    bit          m_err   = 0;
    int unsigned m_count = 0;

    function automatic int pick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++)
            if (r[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            m_phase = 0; m_ptr = 0; m_win = 0; m_err = 0; m_count = 0;
        end else begin
            case (m_phase)
                0: begin
                    if (src_ack) m_err = 1;
                    if (cli_req != 0) begin
                        m_win   = pick(cli_req, m_ptr);
                        m_phase = 1;
                    end
                end
                1: if (src_ack) begin
                    exp_q.push_back('{m_win, src_din});
                    m_count++;
                    m_phase = 2;
                end
                default: begin
                    if (src_ack) m_err = 1;
                    m_ptr   = (m_win + 1) % N;
                    m_phase = 0;
                end
            endcase
        end
    end

    // ---------------- monitor / scoreboard ---------------------------------
    int          ack_log[$];
    int          per_cli[N];
    int unsigned seq          = 0;
    int          cyc          = 0;
    int          last_ack_cyc = -1;
    bit          chk_interval = 0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(negedge clk);
        if (rst) begin
            if (cli_ack != 0) check("ack_in_reset", cli_ack, 0);
        end else if (cli_ack != 0) begin
            int   idx;
            exp_t e;
            idx = 0;
            for (int i = 0; i < N; i++) if (cli_ack[i]) idx = i;
            check("ack_onehot", $countones(cli_ack), 1);
            if (exp_q.size() == 0) begin
                check("ack_expected", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("ack_client", idx, e.cli);
                check("ack_data", cli_dout, e.data);
                check("grant_id", grant_id, e.cli);
            end
            check("data_seq", cli_dout, seq);
            check("count", count, m_count);
            check("err", err, m_err);
            if (chk_interval && last_ack_cyc >= 0) check("ack_interval", cyc - last_ack_cyc, 4);
            seq++;
            last_ack_cyc = cyc;
            ack_log.push_back(idx);
            per_cli[idx]++;
        end
    end

    // ---------------- helpers ----------------------------------------------
    task automatic clear_tb();
        exp_q.delete();
        ack_log.delete();
        for (int i = 0; i < N; i++) per_cli[i] = 0;
        seq          = 0;
        next_val     = 0;
        last_ack_cyc = -1;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        clear_tb();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic wait_acks(input int n, input int budget);
        int target;
        target = ack_log.size() + n;
        for (int c = 0; c < budget && ack_log.size() < target; c++) begin
            @(negedge clk); #1;
        end
        if (ack_log.size() < target) check("ack_timeout", ack_log.size(), target);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_src_req"},  src_req,  0);
        check({tag, "_cli_ack"},  cli_ack,  0);
        check({tag, "_cli_dout"}, cli_dout, 0);
        check({tag, "_grant_id"}, grant_id, 0);
        check({tag, "_busy"},     busy,     0);
        check({tag, "_count"},    count,    0);
        check({tag, "_err"},      err,      0);
    endtask

    // ---------------- stimulus ---------------------------------------------
    initial begin
        rst     = 1'b1;
        cli_req = '0;
        clear_tb();
        @(posedge clk); #1;
        check_reset_outputs("rst");
        @(posedge clk); #1 rst = 1'b0;

        // single client, zero-wait source: a word every 4 cycles
        chk_interval = 1;
        cli_req = 4'b0001;
        repeat (41) @(posedge clk);
        @(negedge clk); #1;
        check("single_count40", count, 10);
        check("single_acks", per_cli[0], 10);
        chk_interval = 0;
        cli_req = '0;

        // all clients requesting: strict rotation
        do_reset();
        cli_req = 4'hF;
        wait_acks(8, 100);
        for (int i = 0; i < 8 && i < ack_log.size(); i++) check("rot_order", ack_log[i], i % N);
        wait_acks(992, 5000);
        cli_req = '0;
        for (int i = 0; i < N; i++) check("rot_per_client", per_cli[i], 250);

        // ptr=2 with requests from 0 and 3: 3 wins, then 0
        do_reset();
        cli_req = 4'b0010;
        wait_acks(1, 50);
        cli_req = 4'b1001;
        wait_acks(2, 50);
        cli_req = '0;
        if (ack_log.size() >= 3) begin
            check("ptr2_first", ack_log[1], 3);
            check("ptr2_second", ack_log[2], 0);
        end else check("ptr2_acks", ack_log.size(), 3);

        // granted client drops its request one cycle after the grant
        do_reset();
        cli_req = 4'b0010;
        for (int c = 0; c < 20 && !src_req; c++) begin
            @(posedge clk); #1;
        end
        check("drop_granted", src_req, 1);
        @(posedge clk); #1;
        cli_req = '0;
        repeat (12) @(posedge clk);
        @(negedge clk); #1;
        check("drop_acks", ack_log.size(), 1);
        check("drop_cli1", per_cli[1], 1);
        check("drop_count", count, 1);

        // stalling source, random requests
        do_reset();
        fail_rate = 50;
        for (int c = 0; c < 40000 && ack_log.size() < 5000; c++) begin
            @(posedge clk); #1;
            if ($urandom_range(0, 3) == 0) cli_req = N'($urandom_range(1, 15));
        end
        cli_req   = '0;
        fail_rate = 0;
        repeat (10) @(posedge clk);
        @(negedge clk); #1;
        check("stall_words", ack_log.size() >= 5000, 1);
        check("stall_err", err, 0);
        check("stall_pending", exp_q.size(), 0);
        check("stall_count", count, ack_log.size());

        // reset in the middle of a stalled ISSUE
        do_reset();
        cli_req = 4'b0100;
        wait_acks(3, 50);
        fail_rate = 100;
        repeat (6) @(posedge clk);
        #1;
        check("midrst_busy", busy, 1);
        check("midrst_src_req", src_req, 1);
        #2 rst = 1'b1;
        #1;
        check_reset_outputs("midrst");
        clear_tb();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        fail_rate = 0;
        cli_req = 4'hF;
        wait_acks(1, 50);
        cli_req = '0;
        if (ack_log.size() > 0) check("midrst_resume", ack_log[0], 0);

        // stray source ack while idle sets a sticky err
        repeat (8) @(posedge clk);
        #1 inject = 1;
        repeat (6) @(posedge clk);
        @(negedge clk); #1;
        check("stray_err", err, 1);
        check("stray_err_model", err, m_err);
        check("stray_busy", busy, 0);
        do_reset();
        @(negedge clk); #1;
        check("stray_err_cleared", err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/req_ack_rr_arbiter.md
# req_ack_rr_arbiter

Round-robin arbiter that shares one req/ack data source (a `producer` or the output side of an `async_operator` chain) among `num_clients` req/ack requesters. It sits between a single source port and several consumer-style clients. For each granted request it fetches one word from the source and returns it to the winning client as a one-cycle ack pulse. One transaction completes every 4 cycles, matching the bench throughput normalisation (`count_clock / 4`).

## Interface
Parameters:
- `num_clients`, default 4: number of requesters, range 2..16.
- `data_width`, default 32: width of the data word.

Ports:
- `clk`, input, 1: single clock, rising edge.
- `rst`, input, 1: reset, asynchronous, active-high.
- `cli_req`, input, `num_clients`: per-client request level; bit i belongs to client i.
- `cli_ack`, output, `num_clients`: per-client one-cycle ack pulse, one-hot or zero.
- `cli_dout`, output, `data_width`: shared return bus, valid while any `cli_ack` bit is high.
- `src_req`, output, 1: request to the source.
- `src_ack`, input, 1: one-cycle ack from the source.
- `src_din`, input, `data_width`: source data, valid with `src_ack`.
- `grant_id`, output, `$clog2(num_clients)`: index of the current or last winner.
- `busy`, output, 1: high in any state other than IDLE.
- `count`, output, 32: number of completed transactions, wraps modulo 2^32.
- `err`, output, 1: sticky flag, set by an `src_ack` that arrives outside ISSUE.

## Operation
- The FSM has three states: IDLE, ISSUE, RESP.
- IDLE:
  - If `cli_req` is nonzero, pick the first set bit searching from `ptr` upward with wrap (`ptr`, `ptr`+1, …, `num_clients`-1, 0, …).
  - Register the winner into `grant_id`, set `src_req`<=1 and go to ISSUE.
  - If `cli_req` is zero, stay in IDLE.
- ISSUE:
  - Hold `src_req`=1 until `src_ack` is sampled high.
  - On that edge: `src_req`<=0, `cli_dout`<=`src_din`, `cli_ack[grant_id]`<=1, `count`<=`count`+1, go to RESP.
  - There is no timeout. ISSUE waits indefinitely for a stalled source.
- RESP:
  - `cli_ack`<=0, `ptr`<=(`grant_id`+1) mod `num_clients`, go to IDLE.
  - `cli_dout` holds its value until the next capture.
- The granted client dropping `cli_req` after the grant does not abort the transaction. The ack is still delivered to that client.
- `src_ack` sampled in IDLE or RESP is ignored for data and sets `err`. Only reset clears `err`.
- The pointer update makes sure no requester waits more than `num_clients` transactions.

## Timing
- Reset (asynchronous, immediate) drives the block to:
  - state IDLE;
  - `src_req`=0, `cli_ack`=0, `cli_dout`=0;
  - `grant_id`=0, `ptr`=0;
  - `busy`=0, `count`=0, `err`=0.
- Reset asserted mid-transaction abandons the transaction with no ack pulse. A source ack that arrives after reset is released sets `err` only if the FSM is not in ISSUE.
- Edge numbering with a zero-wait source:
  - E0: IDLE samples `cli_req` and raises `src_req`.
  - E1: the source acks.
  - E2: ISSUE samples `src_ack`; `cli_ack` is high from E2 to E3.
  - E3: the FSM returns to IDLE.
  - E4: the next grant is made.
- Request-sample to client ack latency is 2 cycles. Issue interval is 4 cycles per word.
- Source wait states add 1:1 to both latency and interval.
- `cli_ack` is never high for more than one cycle, and never for more than one client at a time.
- `src_req` is never asserted in the cycle immediately after `src_ack`, so a producer that checks `req & ~ack` never double-issues.

## Structure
- Package `arb_pkg` holds:
  - the state encoding localparams (IDLE=2'd0, ISSUE=2'd1, RESP=2'd2);
  - `count` width 32.
- Sub-module `rr_pick`: purely combinational rotating priority picker.
  - Inputs: `req[num_clients]`, `ptr`.
  - Outputs: `gnt_idx`, `any`.
  - It is instantiated once. The FSM, registers and counters stay in the top module.

## Test plan
- Single client, zero-wait `producer` with `initial_value`=0, `cli_req`=4'b0001 held:
  - client 0 receives acks with `cli_dout` = 0, 1, 2, … every 4 cycles;
  - `count`=10 after 40 cycles from the first grant.
- All four clients requesting continuously:
  - grants go in order 0,1,2,3,0,…;
  - data 0..7 goes to clients 0,1,2,3,0,1,2,3;
  - each client gets exactly 250 acks after 1000 transactions.
- `ptr`=2 with requests from clients 0 and 3 only: the first grant goes to 3, the next to 0.
- Client 1 drops `cli_req` one cycle after the grant: client 1 still gets exactly one ack carrying the fetched word, and `count` increments.
- Source `fail_rate`=50: every ack still arrives in ISSUE, `err` stays 0, and there are no duplicate or lost values across 5000 words.
- Reset pulse during ISSUE: outputs return to their reset values asynchronously, no ack pulse is produced, and arbitration resumes from client 0 after reset is released.
